// File: rtl/mont_preconv.sv
`default_nettype none
// =============================================================================
// Module : mont_preconv (with helper montcios)
// Brief  : Maps an operand into the Montgomery domain (x*R mod n), caching R mod n per key.
// Rev    : 1.0
// =============================================================================

module montcios #(
  parameter int WIDTH = 32,
  parameter int S     = 8,
  parameter int N     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH*S-1:0]   a,
  input  logic [WIDTH*S-1:0]   b,
  input  logic [WIDTH*S-1:0]   p,
  input  logic [WIDTH-1:0]     p_prime,
  output logic                 done,
  output logic [WIDTH*S-1:0]   tout
);
  localparam int c_WS = WIDTH * S;
  // Two spare bits keep the running sum exact: t + a_i*b + m*p < 2^(WS+W+2).
  localparam int c_TW = c_WS + WIDTH + 2;
  localparam int c_CW = $clog2(S + 1) + 1;
  localparam logic [c_CW-1:0] c_LAST = S[c_CW-1:0];
  localparam logic [c_CW-1:0] c_ONE  = {{(c_CW-1){1'b0}}, 1'b1};

  logic [c_TW-1:0]  r_t;
  logic [c_CW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_fin;
  logic [c_WS-1:0]  r_res;
  logic [WIDTH-1:0] w_ai;
  logic [WIDTH-1:0] w_m;
  logic [c_TW-1:0]  w_t1;
  logic [c_TW-1:0]  w_sum;
  logic [c_TW-1:0]  w_p_ext;
  logic [c_TW-1:0]  w_red;

  always_comb begin
    w_ai = '0;
    for (int i = 0; i < S; i++) begin
      if (r_cnt == i[c_CW-1:0]) begin
        w_ai = a[i*WIDTH +: WIDTH];
      end
    end
  end

  // One outer CIOS iteration per cycle: add a_i*b, then cancel the low limb with m*p.
  assign w_p_ext = {{(c_TW-c_WS){1'b0}}, p};
  assign w_t1    = r_t + ({{(c_TW-WIDTH){1'b0}}, w_ai} * {{(c_TW-c_WS){1'b0}}, b});
  assign w_m     = w_t1[WIDTH-1:0] * p_prime;
  assign w_sum   = w_t1 + ({{(c_TW-WIDTH){1'b0}}, w_m} * w_p_ext);
  assign w_red   = (r_t >= w_p_ext) ? (r_t - w_p_ext) : r_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
      r_res  <= '0;
    end else begin
      r_fin <= 1'b0;
      if (start) begin
        r_t    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == c_LAST) begin
          r_res  <= c_WS'(w_red);
          r_fin  <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_t   <= w_sum >> WIDTH;
          r_cnt <= r_cnt + c_ONE;
        end
      end
    end
  end

  assign tout = r_res;

  generate
    if (N == 0) begin : g_no_delay
      assign done = r_fin;
    end else begin : g_delay
      logic [N-1:0] r_dly;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly <= '0;
        end else begin
          for (int k = N - 1; k > 0; k--) begin
            r_dly[k] <= r_dly[k-1];
          end
          r_dly[0] <= r_fin;
        end
      end
      assign done = r_dly[N-1];
    end
  endgenerate

endmodule

module mont_preconv #(
  parameter int WIDTH = 32,
  parameter int S     = 8,
  parameter int N     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*S-1:0]   x,
  input  logic [WIDTH*S-1:0]   modulus,
  input  logic [WIDTH-1:0]     p_prime,
  input  logic [WIDTH*S-1:0]   r2,
  input  logic                 key_load,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*S-1:0]   base_mont,
  output logic [WIDTH*S-1:0]   mont_one
);
  localparam int c_WS = WIDTH * S;
  localparam logic [c_WS-1:0] c_ONE_OPND = {{(c_WS-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ONE_LOAD  = 4'd1,
    ONE_START = 4'd2,
    ONE_WAIT  = 4'd3,
    X_LOAD    = 4'd4,
    X_START   = 4'd5,
    X_WAIT    = 4'd6,
    HOLD      = 4'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [c_WS-1:0]  r_x;
  logic [c_WS-1:0]  r_mod;
  logic [c_WS-1:0]  r_r2;
  logic [WIDTH-1:0] r_pp;
  logic [c_WS-1:0]  r_a;
  logic [c_WS-1:0]  r_b;
  logic             r_mont_start;
  logic             r_one_cached;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_load_one;
  logic             w_load_x;
  logic             w_cap_one;
  logic             w_cap_x;
  logic             w_release;
  logic             w_mont_done;
  logic [c_WS-1:0]  w_tout;

  montcios #(
    .WIDTH (WIDTH),
    .S     (S),
    .N     (N)
  ) u_mont (
    .clk     (clk),
    .rst     (rst),
    .start   (r_mont_start),
    .a       (r_a),
    .b       (r_b),
    .p       (r_mod),
    .p_prime (r_pp),
    .done    (w_mont_done),
    .tout    (w_tout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load_one = 1'b0;
    w_load_x   = 1'b0;
    w_cap_one  = 1'b0;
    w_cap_x    = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          // A key change arriving with the job makes the cached R mod n untrustworthy.
          w_next   = (r_one_cached && !key_load) ? X_LOAD : ONE_LOAD;
        end
      end
      ONE_LOAD: begin
        w_load_one = 1'b1;
        w_next     = ONE_START;
      end
      ONE_START: w_next = ONE_WAIT;
      ONE_WAIT: begin
        if (w_mont_done) begin
          w_cap_one = 1'b1;
          w_next    = X_LOAD;
        end
      end
      X_LOAD: begin
        w_load_x = 1'b1;
        w_next   = X_START;
      end
      X_START: w_next = X_WAIT;
      X_WAIT: begin
        if (w_mont_done) begin
          w_cap_x = 1'b1;
          w_next  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_mod        <= '0;
      r_r2         <= '0;
      r_pp         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mont_start <= 1'b0;
      r_one_cached <= 1'b0;
      r_out_valid  <= 1'b0;
      base_mont    <= '0;
      mont_one     <= '0;
    end else begin
      r_mont_start <= w_load_one | w_load_x;
      if (w_accept) begin
        r_x   <= x;
        r_mod <= modulus;
        r_r2  <= r2;
        r_pp  <= p_prime;
      end
      // mont(1, R^2) = R mod n; mont(x, R^2) = x*R mod n.
      if (w_load_one) begin
        r_a <= c_ONE_OPND;
        r_b <= r_r2;
      end else if (w_load_x) begin
        r_a <= r_x;
        r_b <= r_r2;
      end
      if (w_cap_one) begin
        mont_one <= w_tout;
      end
      if (w_cap_x) begin
        base_mont <= w_tout;
      end
      if (key_load) begin
        r_one_cached <= 1'b0;
      end else if (w_cap_one) begin
        r_one_cached <= 1'b1;
      end
      if (w_cap_x) begin
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mont_preconv.sv
`default_nettype none
// =============================================================================
// Module : tb_mont_preconv
// Brief  : Directed + random jobs against an arithmetic model of x*R mod n and R mod n.
// Rev    : 1.0
// =============================================================================
module tb_mont_preconv;
  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int N     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] modulus;
  logic [7:0]  p_prime;
  logic [15:0] r2;
  logic        key_load;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] base_mont;
  logic [15:0] mont_one;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int ov_cycles = 0;

  logic [15:0] cur_n;
  logic [7:0]  cur_pp;
  logic [15:0] cur_r2;
  bit          m_cached;

  always #5 clk = ~clk;

  mont_preconv #(.WIDTH(WIDTH), .S(S), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .modulus   (modulus),
    .p_prime   (p_prime),
    .r2        (r2),
    .key_load  (key_load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .base_mont (base_mont),
    .mont_one  (mont_one)
  );

  always @(posedge clk) begin
    if (dut.u_mont.start) pulses++;
    if (out_valid) ov_cycles++;
  end

  function automatic logic [15:0] ref_to_mont(input logic [15:0] v, input logic [15:0] n);
    longint unsigned t;
    t = ({48'd0, v} << 16) % {48'd0, n};
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_r2(input logic [15:0] n);
    longint unsigned rm;
    longint unsigned t;
    rm = 64'd65536 % {48'd0, n};
    t  = (rm * rm) % {48'd0, n};
    return t[15:0];
  endfunction

  function automatic logic [7:0] ref_pp(input logic [15:0] n);
    logic [7:0] r;
    logic [7:0] yy;
    logic [7:0] prod;
    r = 8'd0;
    for (int y = 0; y < 256; y++) begin
      yy   = y[7:0];
      prod = n[7:0] * yy;
      if (prod == 8'hFF) r = yy;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key_pulse();
    @(negedge clk);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    m_cached = 1'b0;
  endtask

  task automatic new_key(input logic [15:0] n);
    cur_n  = n;
    cur_pp = ref_pp(n);
    cur_r2 = ref_r2(n);
    key_pulse();
  endtask

  task automatic run_job(input logic [15:0] xv, input bit kl_accept, input bit kl_xwait, input bit hold);
    int p0, o0, exp_p;
    bit got;
    logic [15:0] exp_base, exp_one;
    exp_base = ref_to_mont(xv, cur_n);
    exp_one  = ref_to_mont(16'd1, cur_n);
    if (kl_accept) m_cached = 1'b0;
    exp_p = m_cached ? 1 : 2;
    out_ready = !hold;
    @(negedge clk);
    p0 = pulses;
    o0 = ov_cycles;
    x = xv; modulus = cur_n; p_prime = cur_pp; r2 = cur_r2;
    in_valid = 1'b1;
    key_load = kl_accept;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    key_load = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    x = 16'($urandom); modulus = 16'($urandom); r2 = 16'($urandom); p_prime = 8'($urandom);
    if (kl_xwait) begin
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (pulses - p0 == exp_p) got = 1'b1;
      end
      check("xwait_reached", {31'd0, got}, 32'd1);
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("out_valid_seen", {31'd0, got}, 32'd1);
    check("base_mont", {16'd0, base_mont}, {16'd0, exp_base});
    check("mont_one", {16'd0, mont_one}, {16'd0, exp_one});
    check("in_ready_hold", {31'd0, in_ready}, 32'd0);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        x = 16'($urandom); modulus = 16'($urandom);
        @(negedge clk);
        check("hold_base", {16'd0, base_mont}, {16'd0, exp_base});
        check("hold_one", {16'd0, mont_one}, {16'd0, exp_one});
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("start_pulses", pulses - p0, exp_p);
    check("valid_cycles", ov_cycles - o0, hold ? 11 : 1);
    m_cached = !kl_xwait;
  endtask

  initial begin
    int p0, o0;
    bit got;
    logic [31:0] rv;
    rst = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b1;
    x = '0; modulus = '0; p_prime = '0; r2 = '0;
    m_cached = 1'b0;
    cur_n = 16'h00F1; cur_pp = 8'hEF; cur_r2 = 16'h000F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_base", {16'd0, base_mont}, 32'd0);
    check("rst_one", {16'd0, mont_one}, 32'd0);

    run_job(16'd2, 1'b0, 1'b0, 1'b0);
    run_job(16'd240, 1'b0, 1'b0, 1'b0);
    key_pulse();
    run_job(16'd0, 1'b0, 1'b0, 1'b0);
    run_job(16'd77, 1'b0, 1'b0, 1'b1);
    run_job(16'd150, 1'b0, 1'b1, 1'b0);
    run_job(16'd3, 1'b0, 1'b0, 1'b0);
    run_job(16'd9, 1'b1, 1'b0, 1'b0);

    // Abort in ONE_WAIT with reset
    key_pulse();
    @(negedge clk);
    p0 = pulses;
    x = 16'd5; modulus = cur_n; p_prime = cur_pp; r2 = cur_r2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (pulses - p0 == 1) got = 1'b1;
    end
    check("one_wait_reached", {31'd0, got}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o0 = ov_cycles;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_base", {16'd0, base_mont}, 32'd0);
    check("abort_one", {16'd0, mont_one}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_valid", ov_cycles - o0, 0);
    m_cached = 1'b0;
    run_job(16'd2, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      rv = $urandom_range(65535, 3) | 32'd1;
      new_key(rv[15:0]);
      for (int j = 0; j < 3; j++) begin
        rv = $urandom_range({16'd0, cur_n} - 1, 0);
        run_job(rv[15:0], ($urandom_range(3, 0) == 0), 1'b0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
